// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared counter width, axis totals and idle levels for the video timing generator
package video_timing_pkg;
    localparam int CW = 16;
    localparam logic BLANK_IDLE = 1'b1;

    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic sync_idle(int pol);
        return pol == 0;
    endfunction
endpackage

// File: rtl/vt_axis_counter.sv
// vt_axis_counter: one timing axis (line or frame) with blank/sync decode of the current position
module vt_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 160,
    parameter int FP     = 8,
    parameter int SYNC   = 16,
    parameter int BP     = 16,
    parameter int POL    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          blank,
    output logic          sync,
    output logic          wrap
);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
    localparam logic [CW-1:0] LAST       = CW'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
    localparam logic          IDLE       = sync_idle(POL);

    assign blank = count >= ACT_END;
    assign sync  = (count >= SYNC_START && count < SYNC_END) ? !IDLE : IDLE;
    assign wrap  = count == LAST;

    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (inc) count <= wrap ? '0 : count + CW'(1);
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: registered active/blank/sync timing bundle, advancing only on gen_ce
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 160,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 16,
    parameter int H_BP     = 16,
    parameter int V_ACTIVE = 120,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 6,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          gen_ce,
    input  logic          en,
    output logic          av_out,
    output logic          hb_out,
    output logic          hs_out,
    output logic          vb_out,
    output logic          vs_out,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          sof
);
    logic          adv, h_blank, h_sync, h_wrap, v_blank, v_sync, v_wrap;
    logic [CW-1:0] hc, vc;

    assign adv = en && gen_ce;

    vt_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)) u_h (
        .clk(pclk), .rst(rst), .inc(adv), .clr(!en),
        .count(hc), .blank(h_blank), .sync(h_sync), .wrap(h_wrap)
    );

    vt_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)) u_v (
        .clk(pclk), .rst(rst), .inc(adv && h_wrap), .clr(!en),
        .count(vc), .blank(v_blank), .sync(v_sync), .wrap(v_wrap)
    );

    // Disabled generator parks on the idle bundle; its counters are cleared so restart begins at (0,0)
    always_ff @(posedge pclk)
        if (rst || !en) begin
            av_out  <= 1'b0;
            hb_out  <= BLANK_IDLE;
            vb_out  <= BLANK_IDLE;
            hs_out  <= sync_idle(HS_POL);
            vs_out  <= sync_idle(VS_POL);
            h_count <= '0;
            v_count <= '0;
            sof     <= 1'b0;
        end else if (gen_ce) begin
            av_out  <= !h_blank && !v_blank;
            hb_out  <= h_blank;
            vb_out  <= v_blank;
            hs_out  <= h_sync;
            vs_out  <= v_sync;
            h_count <= hc;
            v_count <= vc;
            sof     <= hc == '0 && vc == '0;
        end else begin
            sof     <= 1'b0;
        end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of a 14x7 small format and the default 200x130 format
module tb_video_timing_gen;
    logic        pclk, rst, gen_ce, en, rst_b;
    logic        av, hb, hs, vb, vs, sof;
    logic [15:0] hcnt, vcnt;
    logic        av_b, hb_b, hs_b, vb_b, vs_b, sof_b;
    logic [15:0] hcnt_b, vcnt_b;
    logic [37:0] got, got_b;
    int          tests = 0, fails = 0;

    localparam logic [37:0] IDLE = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1)
    ) dut (
        .pclk(pclk), .rst(rst), .gen_ce(gen_ce), .en(en),
        .av_out(av), .hb_out(hb), .hs_out(hs), .vb_out(vb), .vs_out(vs),
        .h_count(hcnt), .v_count(vcnt), .sof(sof)
    );

    video_timing_gen #(.HS_POL(0)) dut_big (
        .pclk(pclk), .rst(rst_b), .gen_ce(1'b1), .en(1'b1),
        .av_out(av_b), .hb_out(hb_b), .hs_out(hs_b), .vb_out(vb_b), .vs_out(vs_b),
        .h_count(hcnt_b), .v_count(vcnt_b), .sof(sof_b)
    );

    assign got   = {av, hb, hs, vb, vs, sof, hcnt, vcnt};
    assign got_b = {av_b, hb_b, hs_b, vb_b, vs_b, sof_b, hcnt_b, vcnt_b};

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] req);
        tests++;
        if (obs !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Small format: line 8 active/2 fp/2 sync/2 bp, frame 4/1/1/1, both syncs active-high
    function automatic logic [37:0] exp_s(int eh, int ev, logic s);
        logic b_h, b_v;
        b_h = eh >= 8;
        b_v = ev >= 4;
        return {!b_h && !b_v, b_h, eh == 10 || eh == 11, b_v, ev == 5, s, 16'(eh), 16'(ev)};
    endfunction

    // Default format with active-low hsync
    function automatic logic [37:0] exp_b(int eh, int ev, logic s);
        logic b_h, b_v;
        b_h = eh >= 160;
        b_v = ev >= 120;
        return {!b_h && !b_v, b_h, !(eh >= 168 && eh < 184), b_v, ev == 122 || ev == 123, s, 16'(eh), 16'(ev)};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; gen_ce = 1'b1; rst_b = 1'b1;
        step(); step();
        check("reset", got, IDLE);
        check("reset_big", got_b, {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});

        rst = 1'b0;
        step();
        for (int i = 0; i < 98; i++) begin
            check("frame", got, exp_s(i % 14, i / 14, i == 0));
            step();
        end
        check("sof_period", got, exp_s(0, 0, 1'b1));
        step();
        check("sof_width", got, exp_s(1, 0, 1'b0));

        repeat (4) step();
        check("pre_ce", got, exp_s(5, 0, 1'b0));
        gen_ce = 1'b0;
        step();
        check("ce_hold1", got, exp_s(5, 0, 1'b0));
        step();
        check("ce_hold2", got, exp_s(5, 0, 1'b0));
        gen_ce = 1'b1;
        step();
        check("ce_resume", got, exp_s(6, 0, 1'b0));

        repeat (31) step();
        check("pre_en", got, exp_s(9, 2, 1'b0));
        en = 1'b0;
        step();
        check("en_idle", got, IDLE);
        gen_ce = 1'b0;
        step();
        check("en_idle_noce", got, IDLE);
        en = 1'b1; gen_ce = 1'b1;
        step();
        check("en_restart", got, exp_s(0, 0, 1'b1));

        repeat (97) step();
        check("pre_rst", got, exp_s(13, 6, 1'b0));
        rst = 1'b1;
        step();
        check("rst_mid", got, IDLE);
        rst = 1'b0;
        step();
        check("rst_resume", got, exp_s(0, 0, 1'b1));
        gen_ce = 1'b0;
        step();
        check("sof_ce_low", got, exp_s(0, 0, 1'b0));
        gen_ce = 1'b1;
        step();
        check("after_sof", got, exp_s(1, 0, 1'b0));

        rst_b = 1'b0;
        step();
        for (int i = 0; i < 26000; i++) begin
            check("big_frame", got_b, exp_b(i % 200, i / 200, i == 0));
            step();
        end
        check("big_sof_period", got_b, exp_b(0, 0, 1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
